taylor_seq_ctrl: RTL

- Sequencing controller for the 26-bit fixed-point Taylor stage-2 datapath (3 integer bits, 23 fraction bits).
- Accepts one operand x via a valid/ready handshake and drives the datapath's operand port and four control lines.
- Runs the fixed Horner schedule: multiply by C, add 1/6, multiply by C, add 1/2.
- Captures the datapath output and presents it with a valid/ready handshake to the next stage.

---
 rtl/taylor_pkg.sv | 21 ++
 rtl/taylor_seq_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/taylor_pkg.sv
// Shared types and constants for the Taylor stage-2 block.
// Fixed-point format is unsigned 3.23 throughout.
package taylor_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL1,
        S_ADD1,
        S_MUL2,
        S_ADD2,
        S_DONE
    } state_t;

    localparam int Q_INT  = 3;
    localparam int Q_FRAC = 23;

    localparam logic [25:0] C_HALF  = 26'h0400000;
    localparam logic [25:0] C_SIXTH = 26'h0155555;
    localparam logic [25:0] C_MUL   = 26'h00722C;

endpackage

// File: rtl/taylor_seq_ctrl.sv
// Sequencer for the stage-2 Horner schedule: x*C + 1/6, *C, + 1/2.
// Control lines are decoded from state and the settle counter only.
module taylor_seq_ctrl
    import taylor_pkg::*;
#(
    parameter int WAIT_CYC = 0,
    parameter int W        = 26
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic [W-1:0] IN_X,
    output logic [W-1:0] DP_B,
    input  logic [W-1:0] DP_OUT,
    output logic         MUL_SS,
    output logic         ADD_SS,
    output logic         MUL_SS_EN,
    output logic         ADD_SS_EN,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic [W-1:0] RESULT,
    output logic         BUSY
);

    localparam logic [3:0] L_WAIT = 4'(WAIT_CYC);

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [W-1:0] r_dp_b;
    logic [W-1:0] r_result;

    logic w_last;
    logic w_mul_step;
    logic w_add_step;

    assign w_last     = (r_cnt == 4'd0);
    assign w_mul_step = (r_state == S_MUL1) || (r_state == S_MUL2);
    assign w_add_step = (r_state == S_ADD1) || (r_state == S_ADD2);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_dp_b   <= '0;
            r_result <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (IN_VALID) begin
                        r_dp_b  <= IN_X;
                        r_cnt   <= L_WAIT;
                        r_state <= S_MUL1;
                    end
                end
                S_MUL1, S_ADD1, S_MUL2: begin
                    if (w_last) begin
                        r_cnt   <= L_WAIT;
                        r_state <= state_t'(r_state + 3'd1);
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_ADD2: begin
                    // adder output is combinational; capture it on the load edge
                    if (w_last) begin
                        r_result <= DP_OUT;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    if (OUT_READY) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        IN_READY  = (r_state == S_IDLE);
        BUSY      = (r_state != S_IDLE);
        OUT_VALID = (r_state == S_DONE);
        MUL_SS    = !((r_state == S_MUL2) || (r_state == S_ADD2));
        ADD_SS    = (r_state == S_ADD2);
        MUL_SS_EN = w_mul_step && w_last;
        ADD_SS_EN = w_add_step && w_last;
    end

    assign DP_B   = r_dp_b;
    assign RESULT = r_result;

endmodule
